arty_rst_ctrl: RTL and testbench
================================

ARTY_RST_CTRL -- requirements
Module: arty_rst_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock port clk_in, reset port resetn.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the number of locked synchronizer flops (legal 2..4).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 16, the number of stable-lock cycles before release (legal 1..1024).
REQ-004 The block SHALL have port clk_in  input  1  system clock (MMCM output domain).
REQ-005 The block SHALL have port resetn  input  1  asynchronous active-low block reset.
REQ-006 The block SHALL have port locked  input  1  MMCM lock indication, asynchronous to clk_in.
REQ-007 The block SHALL have port soft_rst  input  1  synchronous pulse that re-runs the hold sequence.
REQ-008 The block SHALL have port clr_stat  input  1  synchronous pulse that clears the lock-loss statistics.
REQ-009 The block SHALL have port sys_resetn  output  1  registered active-low system reset, deasserting synchronously to clk_in.
REQ-010 The block SHALL have port state  output  2  FSM state: 0=WAIT_LOCK, 1=HOLD, 2=RUN; 3 is unused.
REQ-011 The block SHALL have port lock_lost  output  1  sticky flag set by a lock loss seen in RUN.
REQ-012 The block SHALL have port loss_cnt  output  8  saturating count of lock losses seen in RUN.

Function
REQ-013 locked SHALL pass through a SYNC_STAGES-deep flop chain; locked_s is the last stage, and only locked_s SHALL be used by the FSM.
REQ-014 sys_resetn SHALL be 1 exactly when the registered state is RUN, with no combinational path from any input.
REQ-015 In WAIT_LOCK with locked_s=1, the next state SHALL be HOLD and hold_cnt SHALL be set to 0.
REQ-016 In HOLD with locked_s=0, the next state SHALL be WAIT_LOCK and hold_cnt SHALL be set to 0.
REQ-017 In HOLD with locked_s=1 and hold_cnt < HOLD_CYCLES-1, hold_cnt SHALL increment.
REQ-018 In HOLD with locked_s=1 and hold_cnt = HOLD_CYCLES-1, the next state SHALL be RUN.
REQ-019 HOLD SHALL therefore last exactly HOLD_CYCLES cycles when lock stays stable.
REQ-020 In RUN with locked_s=0, the next state SHALL be WAIT_LOCK, lock_lost SHALL be set, and loss_cnt SHALL increment, saturating at 255.
REQ-021 In RUN with locked_s=1 and soft_rst=1, the next state SHALL be HOLD with hold_cnt=0, and the statistics SHALL be unchanged.
REQ-022 If locked_s=0 and soft_rst=1 arrive together in RUN, lock loss SHALL take priority (REQ-020).
REQ-023 soft_rst SHALL be ignored in WAIT_LOCK and in HOLD.
REQ-024 clr_stat=1 SHALL clear lock_lost and loss_cnt on the next edge.
REQ-025 If clr_stat coincides with a lock-loss event, the result SHALL be lock_lost=1 and loss_cnt=1.
REQ-026 Latency: with locked rising before edge 1 and staying high, state SHALL be HOLD after edge SYNC_STAGES+1.
REQ-027 Latency: under the same conditions, sys_resetn SHALL rise after edge SYNC_STAGES+1+HOLD_CYCLES (edge 19 with defaults).
REQ-028 Lock loss latency: sys_resetn SHALL fall after edge SYNC_STAGES+1, counted from the first edge that samples locked=0.
REQ-029 hold_cnt width SHALL be clog2(HOLD_CYCLES), with a minimum of 1.
REQ-030 An encoded state of 3 SHALL recover to WAIT_LOCK on the next edge.

Reset
REQ-031 While resetn=0, all flops SHALL be cleared asynchronously: synchronizer chain, hold_cnt, and statistics to 0, and state to WAIT_LOCK.
REQ-032 While resetn=0, outputs SHALL be sys_resetn=0, state=0, lock_lost=0, loss_cnt=0.
REQ-033 resetn asserted mid-HOLD or mid-RUN SHALL force sys_resetn=0 immediately, without waiting for a clock edge.
REQ-034 After resetn release, the full sequence of REQ-026 and REQ-027 SHALL rerun.
REQ-035 resetn deassertion SHALL be synchronous to clk_in, provided upstream.

Verification
REQ-036 Release resetn with locked=1 held (defaults) -> state=1 after edge 3, sys_resetn=1 after edge 19, loss_cnt=0.
REQ-037 In RUN, drop locked for 5 cycles, then restore it -> sys_resetn=0 by edge 3, lock_lost=1, loss_cnt=1, sys_resetn=1 again 19 edges after the restore.
REQ-038 In HOLD at hold_cnt=10, pulse locked low for 3 cycles -> return to WAIT_LOCK, hold_cnt restarts at 0, no statistics change, full 16-cycle HOLD afterwards.
REQ-039 Cause 300 lock losses, then pulse clr_stat coinciding with one more loss -> loss_cnt saturates at 255, then reads 1 with lock_lost=1.
REQ-040 soft_rst pulse in RUN -> sys_resetn low for exactly 16 cycles, loss_cnt unchanged; soft_rst pulse in HOLD -> no effect.
REQ-041 Assert resetn mid-RUN between clock edges -> sys_resetn=0 before the next edge, and all outputs at their reset values.

Source files
------------

// File: rtl/arty_rst_ctrl.sv
// Reset sequencer for an MMCM-clocked domain: synchronizes the lock flag and keeps
// the system in reset until lock has been stable for HOLD_CYCLES cycles.
module arty_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       locked,
    input  logic       soft_rst,
    input  logic       clr_stat,
    output logic       sys_resetn,
    output logic [1:0] state,
    output logic       lock_lost,
    output logic [7:0] loss_cnt
);
    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        UNUSED    = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [HC_W-1:0]        hold_cnt_reg, hold_cnt_next;
    logic                   lock_lost_reg, lock_lost_next;
    logic [7:0]             loss_cnt_reg, loss_cnt_next;
    logic                   sys_resetn_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   locked_s;
    logic                   loss_event;

    assign locked_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked};
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        loss_event    = 1'b0;
        case (state_reg)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_next    = WAIT_LOCK;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next    = RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + HC_W'(1);
                end
            end
            RUN: begin
                // Lock loss outranks a coincident soft reset.
                if (!locked_s) begin
                    state_next    = WAIT_LOCK;
                    hold_cnt_next = '0;
                    loss_event    = 1'b1;
                end else if (soft_rst) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                end
            end
            default: begin
                state_next    = WAIT_LOCK;
                hold_cnt_next = '0;
            end
        endcase
    end

    // A clear that coincides with a loss leaves exactly that one loss recorded.
    always_comb begin
        lock_lost_next = lock_lost_reg;
        loss_cnt_next  = loss_cnt_reg;
        if (clr_stat) begin
            lock_lost_next = loss_event;
            loss_cnt_next  = {7'd0, loss_event};
        end else if (loss_event) begin
            lock_lost_next = 1'b1;
            if (loss_cnt_reg != 8'hFF) begin
                loss_cnt_next = loss_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= WAIT_LOCK;
            hold_cnt_reg   <= '0;
            lock_lost_reg  <= 1'b0;
            loss_cnt_reg   <= 8'd0;
            sys_resetn_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            lock_lost_reg  <= lock_lost_next;
            loss_cnt_reg   <= loss_cnt_next;
            sys_resetn_reg <= (state_next == RUN);
        end
    end

    assign sys_resetn = sys_resetn_reg;
    assign state      = state_reg;
    assign lock_lost  = lock_lost_reg;
    assign loss_cnt   = loss_cnt_reg;

endmodule

// File: tb/tb_arty_rst_ctrl.sv
// Scenario bench for arty_rst_ctrl: each task queues expected observations at
// chosen edge numbers and checks them as the edges occur.
module tb_arty_rst_ctrl;

    logic       clk_in = 1'b0;
    logic       resetn = 1'b0;
    logic       locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic       clr_stat = 1'b0;
    logic       sys_resetn;
    logic [1:0] state;
    logic       lock_lost;
    logic [7:0] loss_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_lc = 0;

    typedef struct {
        int          at;
        logic [11:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    arty_rst_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(16)) dut (
        .clk_in     (clk_in),
        .resetn     (resetn),
        .locked     (locked),
        .soft_rst   (soft_rst),
        .clr_stat   (clr_stat),
        .sys_resetn (sys_resetn),
        .state      (state),
        .lock_lost  (lock_lost),
        .loss_cnt   (loss_cnt)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected outputs packed as {state, sys_resetn, lock_lost, loss_cnt}.
    function automatic void push(input int at, input logic [1:0] st, input logic srn,
                                 input logic ll, input logic [7:0] lc, input string tag);
        exp_t x;
        x.at  = at;
        x.v   = {st, srn, ll, lc};
        x.tag = tag;
        exp_q.push_back(x);
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [11:0] o;
        resetn = 1'b0; locked = 1'b1; soft_rst = 1'b0; clr_stat = 1'b0;
        step(); step();
        push(0,  2'd0, 1'b0, 1'b0, 8'd0, "reset_values");
        push(2,  2'd0, 1'b0, 1'b0, 8'd0, "still_wait_e2");
        push(3,  2'd1, 1'b0, 1'b0, 8'd0, "hold_e3");
        push(18, 2'd1, 1'b0, 1'b0, 8'd0, "hold_e18");
        push(19, 2'd2, 1'b1, 1'b0, 8'd0, "run_e19");
        push(20, 2'd2, 1'b1, 1'b0, 8'd0, "run_e20");
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                resetn = 1'b1;
                step();
            end
            while (exp_q.size() != 0 && exp_q[0].at == c) begin
                e = exp_q.pop_front();
                o = {state, sys_resetn, lock_lost, loss_cnt};
                n_cmp++;
                if (o !== e.v) begin
                    n_bad++;
                    $display("FAIL %s edge %0d: got %03h want %03h ({st,srn,ll,cnt})", e.tag, c, o, e.v);
                end else $display("ok   %s edge %0d: %03h", e.tag, c, o);
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL reset_leftover: got %0d unchecked, want 0", exp_q.size());
            exp_q.delete();
        end
        exp_lc = 0;
    endtask

    task automatic test_lock_loss();
        exp_t e;
        logic [11:0] o;
        push(2,  2'd2, 1'b1, 1'b0, 8'd0, "loss_still_run_e2");
        push(3,  2'd0, 1'b0, 1'b1, 8'd1, "loss_wait_e3");
        push(7,  2'd0, 1'b0, 1'b1, 8'd1, "loss_wait_e7");
        push(8,  2'd1, 1'b0, 1'b1, 8'd1, "loss_hold_e8");
        push(23, 2'd1, 1'b0, 1'b1, 8'd1, "loss_hold_e23");
        push(24, 2'd2, 1'b1, 1'b1, 8'd1, "loss_run_e24");
        for (int c = 0; c <= 25; c++) begin
            if (c > 0) begin
                locked = (c >= 6);
                step();
            end
            while (exp_q.size() != 0 && exp_q[0].at == c) begin
                e = exp_q.pop_front();
                o = {state, sys_resetn, lock_lost, loss_cnt};
                n_cmp++;
                if (o !== e.v) begin
                    n_bad++;
                    $display("FAIL %s edge %0d: got %03h want %03h ({st,srn,ll,cnt})", e.tag, c, o, e.v);
                end else $display("ok   %s edge %0d: %03h", e.tag, c, o);
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL loss_leftover: got %0d unchecked, want 0", exp_q.size());
            exp_q.delete();
        end
        exp_lc = 1;
    endtask

    task automatic test_soft_rst();
        exp_t e;
        logic [11:0] o;
        push(1,  2'd1, 1'b0, 1'b1, 8'(exp_lc), "soft_hold_e1");
        push(16, 2'd1, 1'b0, 1'b1, 8'(exp_lc), "soft_hold_e16");
        push(17, 2'd2, 1'b1, 1'b1, 8'(exp_lc), "soft_run_e17");
        push(18, 2'd2, 1'b1, 1'b1, 8'(exp_lc), "soft_run_e18");
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) begin
                locked   = 1'b1;
                soft_rst = (c == 1 || c == 5);
                step();
            end
            while (exp_q.size() != 0 && exp_q[0].at == c) begin
                e = exp_q.pop_front();
                o = {state, sys_resetn, lock_lost, loss_cnt};
                n_cmp++;
                if (o !== e.v) begin
                    n_bad++;
                    $display("FAIL %s edge %0d: got %03h want %03h ({st,srn,ll,cnt})", e.tag, c, o, e.v);
                end else $display("ok   %s edge %0d: %03h", e.tag, c, o);
            end
        end
        soft_rst = 1'b0;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL soft_leftover: got %0d unchecked, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_hold_glitch();
        exp_t e;
        logic [11:0] o;
        push(1,  2'd1, 1'b0, 1'b1, 8'(exp_lc), "glitch_hold_e1");
        push(13, 2'd1, 1'b0, 1'b1, 8'(exp_lc), "glitch_hold_e13");
        push(14, 2'd0, 1'b0, 1'b1, 8'(exp_lc), "glitch_wait_e14");
        push(16, 2'd0, 1'b0, 1'b1, 8'(exp_lc), "glitch_wait_e16");
        push(17, 2'd1, 1'b0, 1'b1, 8'(exp_lc), "glitch_hold_e17");
        push(32, 2'd1, 1'b0, 1'b1, 8'(exp_lc), "glitch_hold_e32");
        push(33, 2'd2, 1'b1, 1'b1, 8'(exp_lc), "glitch_run_e33");
        for (int c = 0; c <= 34; c++) begin
            if (c > 0) begin
                soft_rst = (c == 1);
                locked   = !(c >= 12 && c <= 14);
                step();
            end
            while (exp_q.size() != 0 && exp_q[0].at == c) begin
                e = exp_q.pop_front();
                o = {state, sys_resetn, lock_lost, loss_cnt};
                n_cmp++;
                if (o !== e.v) begin
                    n_bad++;
                    $display("FAIL %s edge %0d: got %03h want %03h ({st,srn,ll,cnt})", e.tag, c, o, e.v);
                end else $display("ok   %s edge %0d: %03h", e.tag, c, o);
            end
        end
        soft_rst = 1'b0;
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL glitch_leftover: got %0d unchecked, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [11:0] o;
        // Each round: 3 edges of lost lock, then 19 edges to get back into RUN.
        for (int n = 0; n <= 300; n++) begin
            if (n < 300) begin
                exp_lc = (exp_lc < 255) ? exp_lc + 1 : 255;
                push(3,  2'd0, 1'b0, 1'b1, 8'(exp_lc), "sat_loss");
                push(22, 2'd2, 1'b1, 1'b1, 8'(exp_lc), "sat_run");
            end else begin
                push(3,  2'd0, 1'b0, 1'b1, 8'd1, "clr_with_loss");
                push(22, 2'd2, 1'b1, 1'b1, 8'd1, "clr_with_loss_run");
                push(23, 2'd2, 1'b1, 1'b0, 8'd0, "clr_alone");
            end
            for (int c = 0; c <= ((n < 300) ? 22 : 23); c++) begin
                if (c > 0) begin
                    locked   = (c > 3);
                    clr_stat = (n == 300) && (c == 3 || c == 23);
                    step();
                end
                while (exp_q.size() != 0 && exp_q[0].at == c) begin
                    e = exp_q.pop_front();
                    o = {state, sys_resetn, lock_lost, loss_cnt};
                    n_cmp++;
                    if (o !== e.v) begin
                        n_bad++;
                        $display("FAIL %s #%0d edge %0d: got %03h want %03h ({st,srn,ll,cnt})", e.tag, n, c, o, e.v);
                    end else $display("ok   %s #%0d edge %0d: %03h", e.tag, n, c, o);
                end
            end
            clr_stat = 1'b0;
            if (exp_q.size() != 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sat_leftover #%0d: got %0d unchecked, want 0", n, exp_q.size());
                exp_q.delete();
            end
        end
        exp_lc = 0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [11:0] o;
        push(0,  2'd0, 1'b0, 1'b0, 8'd0, "async_reset_midcycle");
        push(2,  2'd0, 1'b0, 1'b0, 8'd0, "rerun_wait_e2");
        push(3,  2'd1, 1'b0, 1'b0, 8'd0, "rerun_hold_e3");
        push(18, 2'd1, 1'b0, 1'b0, 8'd0, "rerun_hold_e18");
        push(19, 2'd2, 1'b1, 1'b0, 8'd0, "rerun_run_e19");
        locked = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            if (c == 0) begin
                #3 resetn = 1'b0;
                #1;
            end else begin
                if (c == 1) begin
                    @(posedge clk_in);
                    #1 resetn = 1'b1;
                end
                step();
            end
            while (exp_q.size() != 0 && exp_q[0].at == c) begin
                e = exp_q.pop_front();
                o = {state, sys_resetn, lock_lost, loss_cnt};
                n_cmp++;
                if (o !== e.v) begin
                    n_bad++;
                    $display("FAIL %s edge %0d: got %03h want %03h ({st,srn,ll,cnt})", e.tag, c, o, e.v);
                end else $display("ok   %s edge %0d: %03h", e.tag, c, o);
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL async_leftover: got %0d unchecked, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_lock_loss();
        test_soft_rst();
        test_hold_glitch();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
